// File: rtl/stage_pkg.sv
// stage_pkg: shared types and default sizes for the stage pipeline traffic source.
//   stage_src_state_t : burst FSM states (idle, running beats, completion pulse)
//   stage_src_mode_t  : data pattern selector (counting or Galois LFSR)
package stage_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } stage_src_state_t;

  typedef enum logic {
    M_COUNT = 1'b0,
    M_LFSR  = 1'b1
  } stage_src_mode_t;

endpackage

// File: rtl/stage_src_if.sv
// stage_src_if: valid/ready data channel from the burst source into the first stage.
//   data_out  : word to the first stage (stage1_data)
//   valid_out : data_out holds a valid word
//   ready_in  : downstream accepts the word when valid_out & ready_in
// Modports: master = transmitting source, slave = receiving stage.
interface stage_src_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;

  modport master (output data_out, output valid_out, input ready_in);
  modport slave  (input data_out, input valid_out, output ready_in);

endinterface

// File: rtl/stage_lfsr.sv
// stage_lfsr: combinational next-value of a right-shifting Galois LFSR.
//   cur : current register value
//   nxt : value after one shift; TAPS is folded in when the bit shifted out was 1
module stage_lfsr #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] TAPS   = 8'hB8
) (
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] nxt
);

  // One Galois step: shift right, then apply the feedback mask if the outgoing LSB was set
  always_comb begin
    nxt = {1'b0, cur[DATA_W-1:1]};
    if (cur[0]) begin
      nxt = nxt ^ TAPS;
    end else begin
      nxt = nxt;
    end
  end

endmodule

// File: rtl/stage_src.sv
// stage_src: burst traffic source at the head of the stage pipeline.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : burst request, sampled only while idle
//   burst_len  : beats in the burst, latched with start (0 = completion pulse only)
//   mode       : 0 = counting words from 0, 1 = LFSR words from SEED; latched with start
//   tx         : valid/ready channel (data_out, valid_out out; ready_in in)
//   busy       : burst in progress (running or completing)
//   done       : one-cycle pulse at the end of each burst
module stage_src
  import stage_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DEF,
  parameter int                LEN_W  = LEN_W_DEF,
  parameter logic [DATA_W-1:0] SEED   = 8'h01,
  parameter logic [DATA_W-1:0] TAPS   = 8'hB8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             mode,
  stage_src_if.master      tx,
  output logic             busy,
  output logic             done
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  // An all-zero seed would lock the LFSR at zero, so it is promoted to 1
  localparam logic [DATA_W-1:0] SEED_EFF  = (SEED == DATA_ZERO) ? DATA_ONE : SEED;

  stage_src_state_t  state_q, state_d;
  stage_src_mode_t   mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] lfsr_next_s;
  logic              xfer_s;

  stage_lfsr #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_lfsr (
    .cur (data_q),
    .nxt (lfsr_next_s)
  );

  assign xfer_s       = valid_q & tx.ready_in;
  assign tx.data_out  = data_q;
  assign tx.valid_out = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Next-state and next-output logic of the burst FSM
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          mode_d = stage_src_mode_t'(mode);
          busy_d = 1'b1;
          rem_d  = burst_len;
          if (burst_len != LEN_ZERO) begin
            state_d = S_RUN;
            valid_d = 1'b1;
            data_d  = (mode == 1'b1) ? SEED_EFF : DATA_ZERO;
          end else begin
            // Empty burst: go straight to the completion pulse, no beat issued
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (xfer_s) begin
          rem_d  = rem_q - LEN_ONE;
          data_d = (mode_q == M_LFSR) ? lfsr_next_s : (data_q + DATA_ONE);
          if (rem_q == LEN_ONE) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          // Backpressure: word and valid held as they are
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        rem_d   = LEN_ZERO;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_COUNT;
      data_q  <= DATA_ZERO;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= LEN_ZERO;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_stage_src.sv
// tb_stage_src: table-driven and randomized checks of stage_src against a
// word-sequence reference model (word k of a burst computed directly from k).
module tb_stage_src;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] burst_len;
  logic       busy;
  logic       done;

  stage_src_if #(.DATA_W(8)) tx_if ();

  stage_src #(
    .DATA_W (8),
    .LEN_W  (8),
    .SEED   (8'h01),
    .TAPS   (8'hB8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .burst_len (burst_len),
    .mode      (mode),
    .tx        (tx_if.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word k of a burst: k mod 256 in count mode, k LFSR steps from the seed otherwise
  function automatic logic [7:0] model_word(input logic m, input int k);
    logic [7:0] x;
    if (!m) begin
      x = 8'(k % 256);
    end else begin
      x = 8'h01;
      for (int i = 0; i < k; i++) begin
        x = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
      end
    end
    return x;
  endfunction

  // rpol: 0 = ready always high, 1 = random ready, 2 = ready low on cycles 2..4
  task automatic run_burst(input logic m, input int len, input int rpol, input bit inject,
                           output int beats, output logic [7:0] first, output logic [7:0] last);
    int c;
    int k;
    bit got_done;
    logic pv, pr;
    logic [7:0] pd;
    start = 1'b1; mode = m; burst_len = 8'(len);
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); burst_len = 8'($urandom);
    c = 1; k = 0; got_done = 1'b0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
    first = 8'h00; last = 8'h00;
    while (!got_done && c < len * 4 + 100) begin
      if (pv && !pr) begin
        check("hold_valid", tx_if.valid_out, 1);
        check("hold_data", tx_if.data_out, pd);
      end
      case (rpol)
        1:       tx_if.ready_in = 1'($urandom_range(0, 1));
        2:       tx_if.ready_in = !(c >= 2 && c <= 4);
        default: tx_if.ready_in = 1'b1;
      endcase
      start = (inject && c == 2);
      if (done) begin
        got_done = 1'b1;
        check("busy_at_done", busy, 1);
        check("valid_at_done", tx_if.valid_out, 0);
        if (rpol == 0) check("done_cycle", c, len + 1);
      end else begin
        if (tx_if.valid_out && tx_if.ready_in) begin
          check("beat_data", tx_if.data_out, model_word(m, k));
          if (k == 0) first = tx_if.data_out;
          last = tx_if.data_out;
          k++;
        end
        pv = tx_if.valid_out; pr = tx_if.ready_in; pd = tx_if.data_out;
        @(posedge clk); #1;
        c++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    beats = k;
    check("beat_count", k, len);
    start = 1'b0;
    @(posedge clk); #1;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
  endtask

  typedef struct {
    logic       m;
    int         len;
    int         rpol;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int beats;
    logic [7:0] f, l;

    vecs[0] = '{1'b0, 4,   0, 8'h00, 8'h03};
    vecs[1] = '{1'b0, 3,   2, 8'h00, 8'h02};
    vecs[2] = '{1'b1, 3,   0, 8'h01, 8'h5C};
    vecs[3] = '{1'b1, 4,   0, 8'h01, 8'h2E};
    vecs[4] = '{1'b0, 0,   0, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 1,   0, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 255, 0, 8'h00, 8'hFE};
    vecs[7] = '{1'b1, 1,   1, 8'h01, 8'h01};

    // Reset with random inputs
    rst_n = 1'b0;
    start = 1'($urandom); mode = 1'($urandom); burst_len = 8'($urandom);
    tx_if.ready_in = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", tx_if.data_out, 0);
    check("rst_valid", tx_if.valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of directed bursts
    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].m, vecs[i].len, vecs[i].rpol, 1'b0, beats, f, l);
      if (vecs[i].len > 0) begin
        check("vec_first", f, vecs[i].first);
        check("vec_last", l, vecs[i].last);
      end
    end

    // start asserted mid-burst must be ignored
    run_burst(1'b0, 5, 0, 1'b1, beats, f, l);

    // Reset in the middle of a 5-beat burst
    start = 1'b1; mode = 1'b0; burst_len = 8'd5; tx_if.ready_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_data_before", tx_if.data_out, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", tx_if.data_out, 0);
    check("mid_rst_valid", tx_if.valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(1'b0, 5, 0, 1'b0, beats, f, l);
    check("post_rst_first", f, 0);

    // Randomized bursts with random backpressure
    for (int i = 0; i < 12; i++) begin
      run_burst(1'($urandom), $urandom_range(0, 20), 1, 1'b0, beats, f, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
